// File: rtl/tnn_pkg.sv
// Shared definitions for the temporal-logic primitives.
//   GAMMA_DEFAULT / PULSE_DEFAULT : default gamma length and pulse width (aclk cycles)
//   VAL_W_DEFAULT                 : onset-time width for the default gamma length
//   spike_val_t                   : onset time at the default width
//   stage_state_t                 : input staging slot state (EMPTY / FULL)
package tnn_pkg;

    localparam int GAMMA_DEFAULT = 16;
    localparam int PULSE_DEFAULT = 8;
    localparam int VAL_W_DEFAULT = $clog2(GAMMA_DEFAULT);

    typedef logic [VAL_W_DEFAULT-1:0] spike_val_t;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } stage_state_t;

endpackage

// File: rtl/temporal_encoder_ch.sv
// One spike channel: holds the onset time / null flag for the current gamma and
// registers the spike so spk lines up with the gamma_cnt value it belongs to.
//   aclk, rst_n : clock, async active-low reset
//   load        : gamma boundary edge, take load_val/load_null as the new active set
//   load_val    : onset time for the coming gamma
//   load_null   : 1 = no spike in the coming gamma
//   cnt_nxt     : gamma_cnt value that becomes current on this edge
//   spk         : spike output
// Build option TEMPORAL_STEP_EN: step encoding (high from onset to end of gamma)
// instead of a PW-wide pulse.
module temporal_encoder_ch
    import tnn_pkg::*;
#(
    parameter int G     = GAMMA_DEFAULT,
    parameter int PW    = PULSE_DEFAULT,
    parameter int VAL_W = $clog2(G)
) (
    input  logic             aclk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [VAL_W-1:0] load_val,
    input  logic             load_null,
    input  logic [VAL_W-1:0] cnt_nxt,
    output logic             spk
);

    logic [VAL_W-1:0] act_val;
    logic             act_null;
    logic [VAL_W-1:0] t_nxt;
    logic             n_nxt;
    logic             hit;

    // The spike register is evaluated against the values that will be active
    // after this edge, so a freshly loaded t==0 fires in the grst cycle.
    always_comb begin
        t_nxt = load ? load_val  : act_val;
        n_nxt = load ? load_null : act_null;
    end

`ifdef TEMPORAL_STEP_EN
    always_comb hit = (cnt_nxt >= t_nxt);
`else
    localparam logic [VAL_W:0] PW_EXT = (VAL_W+1)'(PW);
    logic [VAL_W:0] win_end;
    // One extra bit so t+PW past the gamma end does not wrap; the counter never
    // exceeds G-1, which gives the truncation at the boundary for free.
    always_comb begin
        win_end = {1'b0, t_nxt} + PW_EXT;
        hit     = (cnt_nxt >= t_nxt) && ({1'b0, cnt_nxt} < win_end);
    end
`endif

    always_ff @(posedge aclk or negedge rst_n) begin
        if (!rst_n) begin
            act_val  <= '0;
            act_null <= 1'b1;
            spk      <= 1'b0;
        end else begin
            if (load) begin
                act_val  <= load_val;
                act_null <= load_null;
            end
            spk <= hit && !n_nxt;
        end
    end

endmodule

// File: rtl/temporal_encoder.sv
// Binary -> temporal spike encoder. Owns the free-running gamma counter, the
// single-slot input staging register and the per-channel spike generators.
//   aclk, rst_n : clock, async active-low reset
//   in_valid    : input vector valid
//   in_ready    : staging slot can take a vector this cycle
//   in_vals     : channel i onset = in_vals[i*VAL_W +: VAL_W]
//   in_null     : 1 = channel i silent in the gamma this vector is emitted in
//   grst        : high while gamma_cnt == 0
//   gamma_cnt   : position within the gamma cycle
//   spk         : per-channel spike outputs
// Build option TEMPORAL_STEP_EN selects step encoding in the channels.
module temporal_encoder
    import tnn_pkg::*;
#(
    parameter int NUM_CH            = 2,
    parameter int GAMMA_CYCLE_WIDTH = GAMMA_DEFAULT,
    parameter int PULSE_WIDTH       = PULSE_DEFAULT,
    parameter int VAL_W             = $clog2(GAMMA_CYCLE_WIDTH)
) (
    input  logic                    aclk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [NUM_CH*VAL_W-1:0] in_vals,
    input  logic [NUM_CH-1:0]       in_null,
    output logic                    grst,
    output logic [VAL_W-1:0]        gamma_cnt,
    output logic [NUM_CH-1:0]       spk
);

    localparam logic [VAL_W-1:0] CNT_LAST = VAL_W'(GAMMA_CYCLE_WIDTH - 1);

    stage_state_t                        state;
    logic [NUM_CH-1:0][VAL_W-1:0]        stg_vals;
    logic [NUM_CH-1:0]                   stg_null;
    logic [NUM_CH-1:0][VAL_W-1:0]        ld_vals;
    logic [NUM_CH-1:0]                   ld_null;
    logic [VAL_W-1:0]                    cnt_nxt;
    logic                                wrap;
    logic                                accept;

    // Power-of-two gamma: natural overflow is the wrap.
    always_comb begin
        cnt_nxt  = gamma_cnt + VAL_W'(1);
        wrap     = (gamma_cnt == CNT_LAST);
        grst     = (gamma_cnt == '0);
        // A FULL slot drains on the wrap edge, so it can refill there.
        in_ready = (state == EMPTY) || wrap;
        accept   = in_valid && in_ready;
    end

    always_ff @(posedge aclk or negedge rst_n) begin
        if (!rst_n) gamma_cnt <= '0;
        else        gamma_cnt <= cnt_nxt;
    end

    // Staging slot. An accept on the wrap edge while EMPTY bypasses the slot
    // straight into the channels (it still lands in the next gamma).
    always_ff @(posedge aclk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= EMPTY;
            stg_vals <= '0;
            stg_null <= '1;
        end else if (accept && !(wrap && state == EMPTY)) begin
            state    <= FULL;
            stg_vals <= in_vals;
            stg_null <= in_null;
        end else if (wrap) begin
            state    <= EMPTY;
        end
    end

    // Active set for the next gamma: staged vector, else a wrap-edge accept,
    // else a silent gamma.
    always_comb begin
        if (state == FULL) begin
            ld_vals = stg_vals;
            ld_null = stg_null;
        end else if (accept) begin
            ld_vals = in_vals;
            ld_null = in_null;
        end else begin
            ld_vals = '0;
            ld_null = '1;
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        temporal_encoder_ch #(
            .G     (GAMMA_CYCLE_WIDTH),
            .PW    (PULSE_WIDTH),
            .VAL_W (VAL_W)
        ) u_ch (
            .aclk      (aclk),
            .rst_n     (rst_n),
            .load      (wrap),
            .load_val  (ld_vals[i]),
            .load_null (ld_null[i]),
            .cnt_nxt   (cnt_nxt),
            .spk       (spk[i])
        );
    end

endmodule

// File: tb/tb_temporal_encoder.sv
module tb_temporal_encoder;
    import tnn_pkg::*;

    localparam int G  = 16;
    localparam int PW = 8;
    localparam int VW = 4;

    logic          aclk = 1'b0;
    logic          rst_n = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [2*VW-1:0] in_vals = '0;
    logic [1:0]    in_null = '0;
    logic          grst;
    logic [VW-1:0] gamma_cnt;
    logic [1:0]    spk;

    int vectors = 0;
    int miss    = 0;

    logic [15:0] m0, m1;

    temporal_encoder #(
        .NUM_CH(2), .GAMMA_CYCLE_WIDTH(G), .PULSE_WIDTH(PW)
    ) dut (
        .aclk(aclk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_vals(in_vals), .in_null(in_null), .grst(grst),
        .gamma_cnt(gamma_cnt), .spk(spk)
    );

    always #5 aclk = ~aclk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miss++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic sync_to(input int c);
        int n;
        n = 0;
        while (gamma_cnt != VW'(c) && n < 40) begin
            tick();
            n++;
        end
        if (n >= 40) chk("sync_timeout", 32'(gamma_cnt), 32'(c));
    endtask

    // Expected spike pattern over one gamma, bit c = spike at gamma_cnt==c.
    function automatic logic [15:0] exp_mask(input int t);
        logic [15:0] m;
        m = '0;
        for (int c = 0; c < G; c++) begin
`ifdef TEMPORAL_STEP_EN
            m[c] = (c >= t);
`else
            m[c] = (c >= t) && (c < t + PW);
`endif
        end
        return m;
    endfunction

    // Record one full gamma of spikes, indexed by the observed gamma_cnt.
    task automatic cap(output logic [15:0] a, output logic [15:0] b);
        a = '0;
        b = '0;
        for (int i = 0; i < G; i++) begin
            a[gamma_cnt] = spk[0];
            b[gamma_cnt] = spk[1];
            tick();
        end
    endtask

    task automatic drive(input logic [VW-1:0] v0, input logic [VW-1:0] v1,
                         input logic [1:0] nl);
        in_vals  = {v1, v0};
        in_null  = nl;
        in_valid = 1'b1;
    endtask

    initial begin
        // reset
        #1 rst_n = 1'b0;
        #2;
        chk("rst_spk", 32'(spk), 0);
        chk("rst_grst", 32'(grst), 1);
        chk("rst_cnt", 32'(gamma_cnt), 0);
        chk("rst_ready", 32'(in_ready), 1);
        repeat (3) @(posedge aclk);
        #1 chk("rst_hold_cnt", 32'(gamma_cnt), 0);
        @(negedge aclk);
        rst_n = 1'b1;

        // first gamma silent, grst once per 16 cycles
        cap(m0, m1);
        chk("idle0_spk0", 32'(m0), 0);
        chk("idle0_spk1", 32'(m1), 0);
        chk("grst_period", 32'(grst), 1);
        tick();
        chk("grst_low", 32'(grst), 0);
        chk("cnt_one", 32'(gamma_cnt), 1);

        // order: ch0=2, ch1=4 accepted in gamma n, emitted in n+1
        sync_to(3);
        drive(4'd2, 4'd4, 2'b00);
        chk("ord_ready", 32'(in_ready), 1);
        tick();
        in_valid = 1'b0;
        chk("ord_full", 32'(in_ready), 0);
        sync_to(0);
        cap(m0, m1);
        chk("ord_spk0", 32'(m0), 32'(exp_mask(2)));  // 0x03fc in pulse mode
        chk("ord_spk1", 32'(m1), 32'(exp_mask(4)));  // 0x0ff0 in pulse mode

        // no accept -> silent gamma
        cap(m0, m1);
        chk("idle_spk0", 32'(m0), 0);
        chk("idle_spk1", 32'(m1), 0);

        // null on ch1
        drive(4'd5, 4'd7, 2'b10);
        tick();
        in_valid = 1'b0;
        sync_to(0);
        cap(m0, m1);
        chk("null_spk0", 32'(m0), 32'(exp_mask(5)));
        chk("null_spk1", 32'(m1), 0);

        // truncation at gamma end, t==0 fires in the grst cycle
        drive(4'd12, 4'd0, 2'b00);
        tick();
        in_valid = 1'b0;
        sync_to(0);
        cap(m0, m1);
        chk("trunc_spk0", 32'(m0), 32'(exp_mask(12)));  // 0xf000 in pulse mode
        chk("zero_spk1", 32'(m1), 32'(exp_mask(0)));    // 0x00ff in pulse mode
        chk("trunc_cnt0_low", 32'(spk), 0);

        // backpressure: B stalls until cnt 15, emitted one gamma after A
        drive(4'd1, 4'd3, 2'b00);
        tick();
        drive(4'd6, 4'd9, 2'b00);
        chk("bp_stall", 32'(in_ready), 0);
        sync_to(15);
        chk("bp_ready15", 32'(in_ready), 1);
        tick();
        in_valid = 1'b0;
        chk("bp_refull", 32'(in_ready), 0);
        cap(m0, m1);
        chk("bpA_spk0", 32'(m0), 32'(exp_mask(1)));
        chk("bpA_spk1", 32'(m1), 32'(exp_mask(3)));
        cap(m0, m1);
        chk("bpB_spk0", 32'(m0), 32'(exp_mask(6)));
        chk("bpB_spk1", 32'(m1), 32'(exp_mask(9)));
        cap(m0, m1);
        chk("bp_nodup0", 32'(m0), 0);
        chk("bp_nodup1", 32'(m1), 0);

        // reset mid-pulse with a vector pending in staging
        drive(4'd2, 4'd8, 2'b00);
        tick();
        in_valid = 1'b0;
        sync_to(0);
        drive(4'd4, 4'd4, 2'b00);
        tick();
        in_valid = 1'b0;
        sync_to(5);
        chk("mid_spk0_high", 32'(spk[0]), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_spk", 32'(spk), 0);
        chk("mid_rst_cnt", 32'(gamma_cnt), 0);
        chk("mid_rst_ready", 32'(in_ready), 1);
        repeat (2) @(posedge aclk);
        @(negedge aclk);
        rst_n = 1'b1;
        cap(m0, m1);
        chk("post_rst_spk0", 32'(m0), 0);
        chk("post_rst_spk1", 32'(m1), 0);
        cap(m0, m1);
        chk("post_rst2_spk0", 32'(m0), 0);
        chk("post_rst2_spk1", 32'(m1), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miss);
        $finish;
    end

endmodule
